// File: rtl/tds_multi_channel_merger.sv
// N-channel TDS strip/pad collector: per-channel FIFOs merged round-robin into one tagged valid/ready stream.
// Optional macro TDS_MERGER_PARITY_EN adds the out_parity port (even parity of out_data).

module tds_merger_ch_fifo #(
  parameter int DATA_W     = 116,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] din,
  input  logic              linked,
  input  logic              mode,
  input  logic              pop,
  output logic              empty,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   cnt, cnt_nxt;
  logic                  link_q, mode_q, flush, push, drop;

  // Losing link or switching mode invalidates whatever was queued.
  assign flush = (link_q & ~linked) | (mode_q != mode);
  assign push  = wr_req & ~full & ~flush;
  assign drop  = wr_req & full & ~flush;
  assign empty = (cnt == '0);
  assign dout  = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (flush)             cnt_nxt = '0;
    else if (push & ~pop)  cnt_nxt = cnt + (DEPTH_LOG2+1)'(1);
    else if (~push & pop)  cnt_nxt = cnt - (DEPTH_LOG2+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      link_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      link_q <= linked;
      mode_q <= mode;
      cnt    <= cnt_nxt;
      full   <= (cnt_nxt == FULL_CNT);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end
endmodule

module tds_multi_channel_merger #(
  parameter  int NUM_CH     = 4,
  parameter  int CH_ID_W    = 2,
  parameter  int DATA_W     = 116,
  parameter  int STRIP_W    = 104,
  parameter  int DEPTH_LOG2 = 4,
  localparam int OUT_W      = DATA_W + CH_ID_W + 1
) (
  input  logic                          clk_readout,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             tds_mode,
  input  logic [NUM_CH-1:0]             ch_linked,
  input  logic [NUM_CH-1:0]             ch_data_valid,
  input  logic [NUM_CH-1:0][DATA_W-1:0] ch_data,
  input  logic                          data_tran_stop,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [OUT_W-1:0]              out_data,
  output logic [NUM_CH-1:0]             ch_fifo_full,
  output logic [NUM_CH-1:0]             ch_overflow,
  output logic [NUM_CH-1:0][15:0]       drop_cnt,
  output logic [31:0]                   word_cnt
`ifdef TDS_MERGER_PARITY_EN
  ,
  output logic                          out_parity
`endif
);
  localparam logic [DATA_W-1:0] STRIP_PAD = {{(DATA_W-STRIP_W){1'b1}}, {STRIP_W{1'b0}}};

  logic [NUM_CH-1:0]             empty, pop;
  logic [NUM_CH-1:0][DATA_W-1:0] dout;
  logic [CH_ID_W-1:0]            last_grant, grant;
  logic                          grant_vld, load;
  logic [OUT_W-1:0]              load_word;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tds_merger_ch_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk      (clk_readout),
      .rst      (reset),
      .wr_req   (ch_data_valid[i] & ch_linked[i] & enable),
      .din      (ch_data[i] | (tds_mode[i] ? STRIP_PAD : '0)),
      .linked   (ch_linked[i]),
      .mode     (tds_mode[i]),
      .pop      (pop[i]),
      .empty    (empty[i]),
      .dout     (dout[i]),
      .full     (ch_fifo_full[i]),
      .overflow (ch_overflow[i]),
      .drop_cnt (drop_cnt[i])
    );
    assign pop[i] = load & (grant == CH_ID_W'(i));
  end

  // Descending scan so the smallest offset from last_grant wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!empty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx[CH_ID_W-1:0];
      end
    end
  end

  assign load      = (~out_valid | out_ready) & ~data_tran_stop & grant_vld;
  assign load_word = {tds_mode[grant], grant, dout[grant]};

  always_ff @(posedge clk_readout or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      last_grant <= CH_ID_W'(NUM_CH - 1);
      word_cnt   <= '0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= load_word;
        last_grant <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid & out_ready) word_cnt <= word_cnt + 32'd1;
    end
  end

`ifdef TDS_MERGER_PARITY_EN
  always_ff @(posedge clk_readout or posedge reset) begin
    if (reset)     out_parity <= 1'b0;
    else if (load) out_parity <= ^load_word;
  end
`endif
endmodule

// File: tb/tb_tds_multi_channel_merger.sv
// Directed bench for tds_multi_channel_merger with default parameters (4 ch, 116b, depth 16).
module tb_tds_multi_channel_merger;
  localparam int NC = 4, DW = 116, OW = 119;

  logic            clk_readout = 1'b0;
  logic            reset;
  logic            enable;
  logic [NC-1:0]   tds_mode, ch_linked, ch_data_valid;
  logic [NC*DW-1:0] ch_data;
  logic            data_tran_stop, out_ready;
  logic            out_valid;
  logic [OW-1:0]   out_data;
  logic [NC-1:0]   ch_fifo_full, ch_overflow;
  logic [NC*16-1:0] drop_cnt;
  logic [31:0]     word_cnt;
`ifdef TDS_MERGER_PARITY_EN
  logic            out_parity;
`endif

  int errors = 0, checks = 0;

  always #5 clk_readout = ~clk_readout;

  tds_multi_channel_merger dut (
    .clk_readout   (clk_readout),
    .reset         (reset),
    .enable        (enable),
    .tds_mode      (tds_mode),
    .ch_linked     (ch_linked),
    .ch_data_valid (ch_data_valid),
    .ch_data       (ch_data),
    .data_tran_stop(data_tran_stop),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .ch_fifo_full  (ch_fifo_full),
    .ch_overflow   (ch_overflow),
    .drop_cnt      (drop_cnt),
    .word_cnt      (word_cnt)
`ifdef TDS_MERGER_PARITY_EN
    ,
    .out_parity    (out_parity)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_readout);
    @(negedge clk_readout);
  endtask

  task automatic push1(input int ch, input logic [DW-1:0] d);
    ch_data_valid = '0;
    ch_data_valid[ch] = 1'b1;
    ch_data[ch*DW +: DW] = d;
    tick();
    ch_data_valid = '0;
  endtask

  function automatic logic [OW-1:0] word(input logic m, input int ch, input logic [DW-1:0] p);
    return {m, 2'(ch), p};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; tds_mode = '0; ch_linked = '0; ch_data_valid = '0;
    ch_data = '0; data_tran_stop = 1'b0; out_ready = 1'b0;
    @(negedge clk_readout); @(negedge clk_readout);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_full", ch_fifo_full, 0);
    chk("rst_ovf", ch_overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_wcnt", word_cnt, 0);
    reset = 1'b0;
    tick();
    ch_linked = '1; enable = 1'b1; out_ready = 1'b1;
    tick(); tick();

    // pad word on ch0: two-cycle latency
    push1(0, 116'h1234);
    chk("lat_t1", out_valid, 0);
    tick();
    chk("lat_t2", out_valid, 1);
    chk("pad_word", out_data, word(1'b0, 0, 116'h1234));
    tick();
    chk("wcnt1", word_cnt, 1);
    chk("drain_valid", out_valid, 0);

    // strip word on ch2
    tds_mode[2] = 1'b1;
    tick(); tick();
    push1(2, 116'hABC);
    tick();
    chk("strip_word", out_data, {1'b1, 2'd2, 12'hFFF, 104'hABC});
    tick();
    chk("wcnt2", word_cnt, 2);
    tds_mode[2] = 1'b0;
    tick(); tick();

    // single ch3 word sets last_grant=3
    push1(3, 116'h33);
    tick(); tick();
    chk("wcnt3", word_cnt, 3);

    // two simultaneous bursts, each served ch0..ch3
    for (int b = 0; b < 2; b++) begin
      ch_data_valid = '1;
      for (int i = 0; i < NC; i++) ch_data[i*DW +: DW] = DW'(16*(b+1) + i);
      tick();
      ch_data_valid = '0;
      for (int i = 0; i < NC; i++) begin
        tick();
        chk($sformatf("burst%0d_ch%0d", b, i), out_data, word(1'b0, i, DW'(16*(b+1) + i)));
      end
    end
    tick();
    chk("wcnt_burst", word_cnt, 11);

    // overflow on ch1 with output stalled
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ch_data_valid = '0;
      ch_data_valid[1] = 1'b1;
      ch_data[DW +: DW] = DW'(100 + k);
      tick();
      if (k >= 1) chk($sformatf("hold_%0d", k), out_data, word(1'b0, 1, DW'(100)));
    end
    ch_data_valid = '0;
    chk("ovf_valid", out_valid, 1);
    chk("ovf_full", ch_fifo_full[1], 1);
    chk("ovf_drop", drop_cnt[16 +: 16], 3);
    chk("ovf_sticky", ch_overflow[1], 1);
    chk("ovf_other_drop", drop_cnt[0 +: 16], 0);

    // drain to 5 queued words, then flush by link loss
    out_ready = 1'b1;
    tick();
    chk("drain_full", ch_fifo_full[1], 0);
    for (int n = 1; n < 11; n++) tick();
    out_ready = 1'b0;
    chk("drain_word", out_data, word(1'b0, 1, DW'(111)));
    chk("wcnt_drain", word_cnt, 22);
    ch_linked[1] = 1'b0;
    tick();
    chk("flush_ovf", ch_overflow[1], 0);
    chk("flush_drop", drop_cnt[16 +: 16], 3);
    chk("flush_keep", out_data, word(1'b0, 1, DW'(111)));
    ch_linked[1] = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("flush_empty", out_valid, 0);
    chk("wcnt_flush", word_cnt, 23);
    tick();
    chk("flush_empty2", out_valid, 0);

    // data_tran_stop: held word delivered once, queue preserved
    out_ready = 1'b0;
    push1(0, 116'hA);
    push1(0, 116'hB);
    data_tran_stop = 1'b1;
    tick();
    chk("stop_hold_v", out_valid, 1);
    chk("stop_hold_d", out_data, word(1'b0, 0, 116'hA));
    out_ready = 1'b1;
    tick();
    chk("stop_deliver", out_valid, 0);
    chk("wcnt_stop", word_cnt, 24);
    out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    chk("stop_idle", out_valid, 0);
    chk("wcnt_idle", word_cnt, 24);
    data_tran_stop = 1'b0;
    tick();
    chk("resume_v", out_valid, 1);
    chk("resume_d", out_data, word(1'b0, 0, 116'hB));
    tick();
    chk("wcnt_end", word_cnt, 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
